// File: rtl/bcd_to_bi_seq_pkg.sv
// Shared types and constants for the sequential 3-digit BCD to binary converter.
// Also holds the digit-range check that both the converter and any checker can reuse.
package bcd_to_bi_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BCD_DIGITS = 3;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int BIN_W      = 10;
    localparam int ITER       = 10;
    localparam int DIGIT_MAX  = 9;
    localparam int OVF8_LIMIT = 255;

    // Returns 1 when any packed BCD digit lies outside 0..9.
    function automatic logic bcd_has_invalid(input logic [BCD_W-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'(DIGIT_MAX)) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_to_bi_seq_sub3_if_ge8.sv
// Per-digit correction step for reverse double dabble:
// a digit that reads 8 or more after the right shift has 3 subtracted.
module sub3_if_ge8 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Subtract 3 from digits of 8 and above, pass smaller digits through.
    always_comb begin
        dout = din;
        if (din >= 4'd8) begin
            dout = din - 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bcd_to_bi_seq.sv
// Sequential 3-digit BCD to 10-bit binary converter using reverse double dabble,
// one shift per clock, with digit-range error and >255 overflow flags.
module bcd_to_bi_seq
    import bcd_to_bi_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       f,
    input  logic [3:0]       s,
    input  logic [3:0]       t,
    output logic             busy,
    output logic             done,
    output logic [BIN_W-1:0] bin,
    output logic             err,
    output logic             ovf8
);

    state_t           state_r;
    logic [3:0]       cnt_r;
    logic [BCD_W-1:0] bcd_r;
    logic [BIN_W-1:0] acc_r;
    logic             err_pend_r;

    logic [BCD_W-1:0] bcd_shift_s;
    logic [BCD_W-1:0] bcd_corr_s;
    logic [BIN_W-1:0] acc_shift_s;
    logic             start_bad_s;

    // Right shift of the combined {bcd, binary} register; BCD LSB enters binary MSB.
    always_comb begin
        bcd_shift_s = {1'b0, bcd_r[BCD_W-1:1]};
        acc_shift_s = {bcd_r[0], acc_r[BIN_W-1:1]};
        start_bad_s = bcd_has_invalid({f, s, t});
    end

    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_corr
        sub3_if_ge8 u_sub3 (
            .din  (bcd_shift_s[4*gi +: 4]),
            .dout (bcd_corr_s[4*gi +: 4])
        );
    end

    // Control FSM, iteration counter, shift registers and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            bcd_r      <= '0;
            acc_r      <= '0;
            err_pend_r <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bin        <= '0;
            err        <= 1'b0;
            ovf8       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        bcd_r <= {f, s, t};
                        acc_r <= '0;
                        cnt_r <= 4'd0;
                        if (start_bad_s) begin
                            // Out-of-range digit: report immediately, no conversion.
                            err_pend_r <= 1'b1;
                            busy       <= 1'b0;
                            state_r    <= DONE;
                        end else begin
                            err_pend_r <= 1'b0;
                            busy       <= 1'b1;
                            state_r    <= CONV;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CONV: begin
                    bcd_r <= bcd_corr_s;
                    acc_r <= acc_shift_s;
                    if (cnt_r == 4'(ITER - 1)) begin
                        cnt_r   <= 4'd0;
                        busy    <= 1'b0;
                        state_r <= DONE;
                    end else begin
                        cnt_r   <= cnt_r + 4'd1;
                        state_r <= CONV;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    bin     <= acc_r;
                    err     <= err_pend_r;
                    ovf8    <= (acc_r > 10'(OVF8_LIMIT));
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    cnt_r   <= 4'd0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bi_seq.sv
// Directed self-checking bench for bcd_to_bi_seq: latency, flags, ignored starts,
// async reset abort, back-to-back period and an exhaustive sweep of valid inputs.
module tb_bcd_to_bi_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] f;
    logic [3:0] s;
    logic [3:0] t;
    logic       busy;
    logic       done;
    logic [9:0] bin;
    logic       err;
    logic       ovf8;

    int vec_cnt;
    int miss_cnt;

    bcd_to_bi_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .f     (f),
        .s     (s),
        .t     (t),
        .busy  (busy),
        .done  (done),
        .bin   (bin),
        .err   (err),
        .ovf8  (ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start one conversion from a negedge and follow it to the done pulse.
    task automatic run(input string tag, input logic [3:0] fi, input logic [3:0] si,
                       input logic [3:0] ti, input logic [9:0] exp_bin,
                       input logic exp_err, input logic exp_ovf, input int exp_lat);
        int         k;
        int         busy_cyc;
        logic       hold_bad;
        logic [9:0] prev_bin;
        prev_bin = bin;
        hold_bad = 1'b0;
        busy_cyc = 0;
        f = fi; s = si; t = ti;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        f = 4'hF; s = 4'hE; t = 4'hC;
        @(negedge clk);
        k = 0;
        while (!done && k < 20) begin
            if (busy) busy_cyc++;
            if (bin !== prev_bin) hold_bad = 1'b1;
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, k, exp_lat);
        chk({tag, "_bin"}, bin, exp_bin);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_ovf8"}, ovf8, exp_ovf);
        chk({tag, "_busy"}, busy_cyc, (exp_lat == 11) ? 10 : 0);
        chk({tag, "_hold"}, hold_bad, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_pulse"}, done, 1'b0);
    endtask

    initial begin
        int         done_cnt;
        int         first_cyc;
        int         second_cyc;
        logic [9:0] seen_bin;
        logic [9:0] exp_v;

        vec_cnt  = 0;
        miss_cnt = 0;
        rst   = 1'b1;
        start = 1'b0;
        f = 4'd0; s = 4'd0; t = 4'd0;
        #3;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_bin", bin, 10'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_ovf8", ovf8, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run("d255", 4'd2, 4'd5, 4'd5, 10'h0FF, 1'b0, 1'b0, 11);
        run("d999", 4'd9, 4'd9, 4'd9, 10'h3E7, 1'b0, 1'b1, 11);
        run("d000", 4'd0, 4'd0, 4'd0, 10'h000, 1'b0, 1'b0, 11);
        run("d256", 4'd2, 4'd5, 4'd6, 10'h100, 1'b0, 1'b1, 11);
        run("inv1a3", 4'd1, 4'hA, 4'd3, 10'h000, 1'b1, 1'b0, 1);
        run("d807", 4'd8, 4'd0, 4'd7, 10'h327, 1'b0, 1'b1, 11);
        run("invf", 4'hF, 4'd0, 4'd0, 10'h000, 1'b1, 1'b0, 1);
        run("d010", 4'd0, 4'd1, 4'd0, 10'h00A, 1'b0, 1'b0, 11);

        // Second start on the third CONV cycle must be ignored.
        f = 4'd3; s = 4'd4; t = 4'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        f = 4'd7; s = 4'd7; t = 4'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_cnt = 0;
        seen_bin = 10'd0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                seen_bin = bin;
            end
        end
        chk("ign_done_cnt", done_cnt, 1);
        chk("ign_bin", seen_bin, 10'h159);

        // Reset during CONV: outputs clear immediately and no done appears.
        f = 4'd5; s = 4'd0; t = 4'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_bin", bin, 10'd0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_err", err, 1'b0);
        chk("arst_ovf8", ovf8, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("arst_no_done", done_cnt, 0);
        run("d128", 4'd1, 4'd2, 4'd8, 10'h080, 1'b0, 1'b0, 11);

        // start held high: back-to-back conversions every 12 cycles.
        f = 4'd2; s = 4'd5; t = 4'd5;
        start = 1'b1;
        done_cnt   = 0;
        first_cyc  = -1;
        second_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                if (done_cnt == 0) first_cyc = i;
                if (done_cnt == 1) second_cyc = i;
                done_cnt++;
                chk("b2b_bin", bin, 10'h0FF);
            end
        end
        start = 1'b0;
        chk("b2b_period", second_cyc - first_cyc, 12);
        repeat (15) @(negedge clk);

        for (int fi = 0; fi < 10; fi++) begin
            for (int si = 0; si < 10; si++) begin
                for (int ti = 0; ti < 10; ti++) begin
                    exp_v = 10'(100 * fi + 10 * si + ti);
                    run("exh", 4'(fi), 4'(si), 4'(ti), exp_v, 1'b0,
                        (exp_v > 10'd255), 11);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
